// File: rtl/mon_chk_pkg.sv
// Shared types and constants for the monitor commit checker.
package mon_chk_pkg;

  localparam int unsigned ERR_W = 3;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE      = 3'd0,
    ERR_GAP       = 3'd1,
    ERR_ORDER     = 3'd2,
    ERR_PC        = 3'd3,
    ERR_POST_HALT = 3'd4,
    ERR_TIMEOUT   = 3'd5
  } err_code_t;

  // Checker states kept as plain constants so older code can still compare raw codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;
  localparam state_t ST_FAULT  = 2'd3;

endpackage

// File: rtl/mon_watchdog.sv
// Idle-cycle watchdog: counts armed cycles without a kick and flags the cycle
// on which the count reaches TIMEOUT.
module mon_watchdog #(
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || kick || !arm) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Combinational so the owner can register the fault on the very edge the count hits TIMEOUT.
  assign expire = arm && !kick && (idle_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mon_commit_checker.sv
// Consumer-side checker for the monitor commit channels: order continuity,
// channel packing, PC chaining, halt discipline and forward progress.
module mon_commit_checker
  import mon_chk_pkg::*;
#(
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned TIMEOUT  = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid    [CHANNELS],
  input  logic [63:0]               order    [CHANNELS],
  input  logic                      halt     [CHANNELS],
  input  logic [31:0]               pc_rdata [CHANNELS],
  input  logic [31:0]               pc_wdata [CHANNELS],
  output logic                      error,
  output err_code_t                 err_code,
  output logic [$clog2(CHANNELS):0] err_chan,
  output logic [63:0]               err_order,
  output logic                      halted,
  output logic                      done,
  output logic [63:0]               commit_count,
  output logic [63:0]               cycle_count
);

  localparam int unsigned CW = $clog2(CHANNELS) + 1;

  state_t      state;
  logic [63:0] exp_order;
  logic [31:0] last_pc;
  logic        pc_skip;

  logic [CHANNELS*ERR_W-1:0] ch_codes;

  logic [CW-1:0]  k;
  logic           any_halt;
  logic [31:0]    last_pc_n;
  logic           fault;
  err_code_t      f_code;
  logic [CW-1:0]  f_chan;
  logic [63:0]    f_order;
  logic           expire;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic        hole;
    logic        prior_halt;
    logic        pc_check;
    logic [31:0] pred_pc;
    err_code_t   code;

    if (g == 0) begin : g_first
      assign hole       = 1'b0;
      assign prior_halt = 1'b0;
      assign pred_pc    = last_pc;
      assign pc_check   = !pc_skip;
    end else begin : g_rest
      always_comb begin
        hole       = 1'b0;
        prior_halt = 1'b0;
        for (int unsigned j = 0; j < g; j++) begin
          hole       = hole | !valid[j];
          prior_halt = prior_halt | (valid[j] & halt[j]);
        end
      end
      assign pred_pc  = pc_wdata[g-1];
      assign pc_check = 1'b1;
    end

    always_comb begin
      code = ERR_NONE;
      if (valid[g]) begin
        if (hole) begin
          code = ERR_GAP;
        end else if (order[g] != exp_order + 64'(g)) begin
          code = ERR_ORDER;
        end else if (pc_check && (pc_rdata[g] != pred_pc)) begin
          code = ERR_PC;
        end else if ((state == ST_HALTED) || prior_halt) begin
          code = ERR_POST_HALT;
        end
      end
    end

    assign ch_codes[g*ERR_W +: ERR_W] = code;
  end

  always_comb begin
    k         = '0;
    any_halt  = 1'b0;
    last_pc_n = last_pc;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (valid[i]) begin
        k         = k + CW'(1);
        any_halt  = any_halt | halt[i];
        last_pc_n = pc_wdata[i];
      end
    end
  end

  mon_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .arm    (state == ST_RUN),
    .kick   (k != '0),
    .expire (expire)
  );

  // Lowest faulting channel wins; timeout only when no channel faulted.
  always_comb begin
    fault   = 1'b0;
    f_code  = ERR_NONE;
    f_chan  = '0;
    f_order = exp_order;
    if (state != ST_FAULT) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!fault && (ch_codes[i*ERR_W +: ERR_W] != ERR_NONE)) begin
          fault   = 1'b1;
          f_code  = err_code_t'(ch_codes[i*ERR_W +: ERR_W]);
          f_chan  = CW'(i);
          f_order = exp_order + 64'(i);
        end
      end
      if (!fault && expire) begin
        fault  = 1'b1;
        f_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      exp_order    <= '0;
      last_pc      <= '0;
      pc_skip      <= 1'b1;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      err_chan     <= '0;
      err_order    <= '0;
      halted       <= 1'b0;
      done         <= 1'b0;
      commit_count <= '0;
      cycle_count  <= '0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (fault) begin
        state     <= ST_FAULT;
        error     <= 1'b1;
        err_code  <= f_code;
        err_chan  <= f_chan;
        err_order <= f_order;
        done      <= 1'b0;
      end else begin
        commit_count <= commit_count + 64'(k);
        if ((k != '0) && (state != ST_FAULT)) begin
          exp_order <= exp_order + 64'(k);
          last_pc   <= last_pc_n;
          pc_skip   <= 1'b0;
          if (any_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            done   <= 1'b1;
          end else if (state == ST_IDLE) begin
            state <= ST_RUN;
          end
        end
      end
    end
  end

endmodule

// File: doc/mon_commit_checker.md
# mon_commit_checker

Consumer-side checker for the monitor commit channels. It samples the per-channel retirement stream the core drives every cycle and checks commit-order continuity, channel packing, PC chaining, halt discipline and forward progress. It reports a sticky error with a first-fault code, plus commit and cycle counters. It sits in the HVL bench beside the reference-model comparator and does not load the DUT.

## Interface
- CHANNELS, 1: commit channels per cycle; channel 0 is oldest.
- TIMEOUT, 2000: maximum cycles with no commit while in RUN.
- clk  in  1  bench clock.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1 [CHANNELS]  channel carries a retired instruction.
- order  in  64 [CHANNELS]  retirement sequence number.
- halt  in  1 [CHANNELS]  retired instruction is the halt.
- pc_rdata  in  32 [CHANNELS]  PC of the retired instruction.
- pc_wdata  in  32 [CHANNELS]  next PC after the retired instruction.
- error  out  1  sticky fault flag.
- err_code  out  3  first fault code (err_code_t).
- err_chan  out  $clog2(CHANNELS)+1  channel of the first fault; 0 for timeout.
- err_order  out  64  expected order value at the first fault.
- halted  out  1  halt committed cleanly.
- done  out  1  halted && !error.
- commit_count  out  64  total valid commits.
- cycle_count  out  64  cycles since reset release.

## Operation
- States: IDLE (no commit yet), RUN, HALTED, FAULT.
- Per cycle, with k = number of valid channels, every valid channel i is checked in ascending i:
  - GAP: valid[i] with valid[j]=0 for some j<i.
  - ORDER: order[i] != exp_order + i.
  - PC: pc_rdata[i] != the predecessor's pc_wdata. The predecessor is channel i-1 in the same cycle, or the last_pc register for i=0. The PC check is skipped for the very first commit after reset.
  - POST_HALT: valid in state HALTED, or valid[i] when halt[j]=1 for some j<i in the same cycle.
- Error priority within a cycle: lowest faulting channel first. Within one channel: GAP > ORDER > PC > POST_HALT.
- On the clean cycle of a commit:
  - exp_order += k (mod 2^64).
  - last_pc = pc_wdata of the highest valid channel.
  - commit_count += k.
  - The watchdog clears.
- Transitions:
  - IDLE→RUN on the first clean commit.
  - RUN→HALTED on a clean commit with any halt set.
  - Any state→FAULT on the first detected fault.
  - The watchdog fires in RUN only: TIMEOUT consecutive cycles with k=0 gives TIMEOUT. IDLE and HALTED do not time out.
- FAULT is terminal until rst. error, err_code, err_chan and err_order freeze at the first fault. Counters keep counting after a fault.
- exp_order starts at 0.
- err_code values: NONE=0, GAP=1, ORDER=2, PC=3, POST_HALT=4, TIMEOUT=5.

## Timing
- All outputs are registered. A fault sampled at edge N makes error=1 visible after edge N.
- halted rises the cycle after the halt commit is sampled.
- Reset values: error=0, err_code=NONE, err_chan=0, err_order=0, halted=0, done=0, commit_count=0, cycle_count=0. Reset also sets state=IDLE, exp_order=0 and watchdog=0, and re-arms the first-commit PC skip.
- Reset asserted mid-run behaves identically to power-on reset, including out of FAULT.
- The timeout asserts on the edge at which the idle counter reaches TIMEOUT, i.e. exactly TIMEOUT idle cycles after the last commit.
- Halt and a fault in the same cycle: the fault wins and the state becomes FAULT. halted stays 0.
- cycle_count increments every non-reset cycle. Both 64-bit counters wrap mod 2^64.

## Structure
- The shared package mon_chk_pkg holds:
  - err_code_t (3-bit enum);
  - state_t (IDLE/RUN/HALTED/FAULT);
  - ERR_W.
- Sub-module mon_watchdog: a parameterised idle counter with inputs kick and arm, and a single-cycle expire output.
- The per-channel checks are a generate loop in the top.

## Test plan
- CHANNELS=2, six commits order 0..5 over three cycles, chained PCs from 0x1eceb000 in +4 steps, halt on order 5 → halted=1, done=1, commit_count=6, error=0.
- Channel 1 valid with channel 0 idle → err_code=1 (GAP), err_chan=1, error on the next cycle.
- Commit order 0,1 then 3 → err_code=2 (ORDER), err_order=2.
- Commit with pc_wdata 0x1eceb004, next commit with pc_rdata 0x1eceb008 → err_code=3 (PC).
- TIMEOUT=10, one commit then 10 idle cycles → error=1 and err_code=5 exactly 10 cycles after the commit. A repeat run with 9 idle cycles gives no error.
- Halt on channel 0 with channel 1 valid the same cycle → err_code=4 (POST_HALT), halted=0. rst for one cycle then clears all outputs to their reset values.
